// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO: default geometry, thresholds
// and read-mode encodings.
package fifo_pkg;
  localparam int DEF_DATA_W    = 128;
  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_AE_THRESH = 2;

  localparam int FWFT_STD  = 0;
  localparam int FWFT_FALL = 1;

  // almost_full default sits two words below the top of the FIFO
  function automatic int af_default(input int addr_w);
    return (1 << addr_w) - 2;
  endfunction
endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_W storage, one write port and one registered read port.
// A read of the address being written returns the new word (write-first).
module sync_fifo_ram #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
  end
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read mode,
// occupancy/threshold flags and one-cycle handshake/error pulses.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FWFT      = FWFT_STD,
  parameter int AF_THRESH = af_default(ADDR_W),
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              wr_ack,
  output logic              overflow,
  output logic              valid,
  output logic              underflow,
  output logic [ADDR_W:0]   data_count
);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);
  localparam logic [ADDR_W:0] CNT_1   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_1 = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt, ram_raddr;
  logic [ADDR_W:0]   cnt;
  logic [DATA_W-1:0] q, head;
  logic              vld, dout_ok;
  logic              wr_acc, rd_acc, ram_we, ram_re, mem_empty;
  logic              load_din, load_q;

  assign full   = (cnt == DEPTH_C);
  assign wr_acc = wr_en && !full;
  // in FWFT mode the RAM holds everything except the word parked in head
  assign mem_empty = (cnt == (ADDR_W+1)'(vld));

  always_comb begin
    rd_acc    = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    load_din  = 1'b0;
    load_q    = 1'b0;
    if (FWFT == FWFT_FALL) begin
      rd_acc = rd_en && vld;
      ram_re = 1'b1;
      // an empty RAM means the incoming word bypasses straight into head
      if (wr_acc && (!vld || (rd_acc && mem_empty))) load_din = 1'b1;
      else                                           ram_we   = wr_acc;
      load_q = rd_acc && !mem_empty;
    end else begin
      rd_acc = rd_en && (cnt != '0);
      ram_re = rd_acc;
      ram_we = wr_acc;
    end
    rd_ptr_nxt = rd_ptr;
    if ((FWFT == FWFT_FALL) ? load_q : rd_acc) rd_ptr_nxt = rd_ptr + PTR_1;
    // FWFT keeps the RAM output pointed at the next head candidate
    ram_raddr = (FWFT == FWFT_FALL) ? rd_ptr_nxt : rd_ptr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      vld       <= 1'b0;
      head      <= '0;
      dout_ok   <= 1'b0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ram_we) wr_ptr <= wr_ptr + PTR_1;
      rd_ptr <= rd_ptr_nxt;
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CNT_1;
        2'b01:   cnt <= cnt - CNT_1;
        default: cnt <= cnt;
      endcase
      wr_ack    <= wr_acc;
      overflow  <= wr_en && full;
      underflow <= rd_en && !rd_acc;
      if (FWFT == FWFT_FALL) begin
        if (load_din)    head <= din;
        else if (load_q) head <= q;
        if (load_din || load_q) vld <= 1'b1;
        else if (rd_acc)        vld <= 1'b0;
      end else begin
        vld <= rd_acc;
        if (rd_acc) dout_ok <= 1'b1;
      end
    end
  end

  sync_fifo_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (q)
  );

  // RAM has no reset, so standard-mode dout is masked until the first real read
  assign dout         = (FWFT == FWFT_FALL) ? head : (dout_ok ? q : '0);
  assign valid        = vld;
  assign empty        = (FWFT == FWFT_FALL) ? !vld : (cnt == '0);
  assign almost_full  = (cnt >= AF_C);
  assign almost_empty = (cnt <= AE_C);
  assign data_count   = cnt;
endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a standard and an FWFT instance side by side, both
// checked every cycle against queue-based models, plus directed tables.
module tb_sync_fifo;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] s_din = '0, f_din = '0;
  logic s_wr = 1'b0, s_rd = 1'b0, f_wr = 1'b0, f_rd = 1'b0;
  logic [DW-1:0] s_dout, f_dout;
  logic s_full, s_empty, s_af, s_ae, s_ack, s_ovf, s_valid, s_unf;
  logic f_full, f_empty, f_af, f_ae, f_ack, f_ovf, f_valid, f_unf;
  logic [AW:0] s_cnt, f_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_W(DW), .ADDR_W(AW), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .din(s_din), .wr_en(s_wr), .rd_en(s_rd), .dout(s_dout),
    .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .wr_ack(s_ack), .overflow(s_ovf), .valid(s_valid), .underflow(s_unf),
    .data_count(s_cnt));

  sync_fifo #(.DATA_W(DW), .ADDR_W(AW), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .din(f_din), .wr_en(f_wr), .rd_en(f_rd), .dout(f_dout),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .wr_ack(f_ack), .overflow(f_ovf), .valid(f_valid), .underflow(f_unf),
    .data_count(f_cnt));

  // reference models: plain word queues plus the last-presented output
  logic [DW-1:0] sq[$], fq[$];
  logic [DW-1:0] m_sdout, m_fdout;
  logic m_svalid, m_sack, m_sovf, m_sunf;
  logic m_fvalid, m_fack, m_fovf, m_funf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sq.delete(); fq.delete();
    m_sdout = '0; m_svalid = 0; m_sack = 0; m_sovf = 0; m_sunf = 0;
    m_fdout = '0; m_fvalid = 0; m_fack = 0; m_fovf = 0; m_funf = 0;
  endtask

  task automatic model_step();
    logic wok, rok;
    if (rst) begin
      model_reset();
      return;
    end
    wok = s_wr && (sq.size() < DEPTH);
    rok = s_rd && (sq.size() > 0);
    m_sack = wok; m_sovf = s_wr && !wok; m_sunf = s_rd && !rok; m_svalid = rok;
    if (rok) m_sdout = sq.pop_front();
    if (wok) sq.push_back(s_din);
    wok = f_wr && (fq.size() < DEPTH);
    rok = f_rd && m_fvalid;
    m_fack = wok; m_fovf = f_wr && !wok; m_funf = f_rd && !rok;
    if (rok) void'(fq.pop_front());
    if (wok) fq.push_back(f_din);
    m_fvalid = (fq.size() > 0);
    if (m_fvalid) m_fdout = fq[0];
  endtask

  task automatic cmp_all();
    chk("s_dout",  32'(s_dout),  32'(m_sdout));
    chk("s_valid", 32'(s_valid), 32'(m_svalid));
    chk("s_ack",   32'(s_ack),   32'(m_sack));
    chk("s_ovf",   32'(s_ovf),   32'(m_sovf));
    chk("s_unf",   32'(s_unf),   32'(m_sunf));
    chk("s_count", 32'(s_cnt),   32'(sq.size()));
    chk("s_full",  32'(s_full),  32'(sq.size() == DEPTH));
    chk("s_empty", 32'(s_empty), 32'(sq.size() == 0));
    chk("s_af",    32'(s_af),    32'(sq.size() >= DEPTH - 2));
    chk("s_ae",    32'(s_ae),    32'(sq.size() <= 2));
    chk("f_dout",  32'(f_dout),  32'(m_fdout));
    chk("f_valid", 32'(f_valid), 32'(m_fvalid));
    chk("f_ack",   32'(f_ack),   32'(m_fack));
    chk("f_ovf",   32'(f_ovf),   32'(m_fovf));
    chk("f_unf",   32'(f_unf),   32'(m_funf));
    chk("f_count", 32'(f_cnt),   32'(fq.size()));
    chk("f_full",  32'(f_full),  32'(fq.size() == DEPTH));
    chk("f_empty", 32'(f_empty), 32'(!m_fvalid));
    chk("f_af",    32'(f_af),    32'(fq.size() >= DEPTH - 2));
    chk("f_ae",    32'(f_ae),    32'(fq.size() <= 2));
  endtask

  task automatic cyc(input logic sw, input logic sr, input logic [DW-1:0] sd,
                     input logic fw, input logic fr, input logic [DW-1:0] fd);
    s_wr = sw; s_rd = sr; s_din = sd;
    f_wr = fw; f_rd = fr; f_din = fd;
    @(posedge clk);
    model_step();
    #1;
    cmp_all();
  endtask

  typedef struct {
    logic          w;
    logic          r;
    logic [DW-1:0] d;
    int            cnt;
    logic          ack;
    logic          ovf;
    logic          vld;
    logic          unf;
    logic [DW-1:0] dout;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic r, input logic [DW-1:0] d,
                              input int cnt, input logic ack, input logic ovf,
                              input logic vld, input logic unf, input logic [DW-1:0] dout);
    vec_t v;
    v.w = w; v.r = r; v.d = d; v.cnt = cnt; v.ack = ack; v.ovf = ovf;
    v.vld = vld; v.unf = unf; v.dout = dout;
    return v;
  endfunction

  function automatic logic [DW-1:0] sseq(input int k);
    return (k < 8) ? DW'(100 + k) : DW'(300 + k - 8);
  endfunction

  function automatic logic [DW-1:0] fseq(input int k);
    return (k < 8) ? DW'(200 + k) : DW'(400 + k - 8);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[34];
    int pw, pr;
    // fill 0..15, overflow on the 17th, then drain 17 times
    for (int i = 0; i < 16; i++)
      tbl[i] = mk(1'b1, 1'b0, DW'(i), i + 1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    tbl[16] = mk(1'b1, 1'b0, DW'(16'h00ff), 16, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int j = 0; j < 16; j++)
      tbl[17 + j] = mk(1'b0, 1'b1, '0, 15 - j, 1'b0, 1'b0, 1'b1, 1'b0, DW'(j));
    tbl[33] = mk(1'b0, 1'b1, '0, 0, 1'b0, 1'b0, 1'b0, 1'b1, DW'(15));

    // reset state, before any clock edge
    #3;
    model_reset();
    cmp_all();
    chk("rst_s_empty", 32'(s_empty), 32'(1));
    chk("rst_f_ae",    32'(f_ae),    32'(1));
    rst = 1'b0;

    for (int i = 0; i < 34; i++) begin
      cyc(tbl[i].w, tbl[i].r, tbl[i].d, 1'b0, 1'b0, '0);
      chk("t_count", 32'(s_cnt),   32'(tbl[i].cnt));
      chk("t_ack",   32'(s_ack),   32'(tbl[i].ack));
      chk("t_ovf",   32'(s_ovf),   32'(tbl[i].ovf));
      chk("t_valid", 32'(s_valid), 32'(tbl[i].vld));
      chk("t_unf",   32'(s_unf),   32'(tbl[i].unf));
      chk("t_dout",  32'(s_dout),  32'(tbl[i].dout));
      chk("t_full",  32'(s_full),  32'(tbl[i].cnt == 16));
      chk("t_empty", 32'(s_empty), 32'(tbl[i].cnt == 0));
      chk("t_af",    32'(s_af),    32'(tbl[i].cnt >= 14));
      chk("t_ae",    32'(s_ae),    32'(tbl[i].cnt <= 2));
    end

    // FWFT single word: falls through, then consumed
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, DW'(16'h00a5));
    chk("fw_valid", 32'(f_valid), 32'(1));
    chk("fw_dout",  32'(f_dout),  32'(16'h00a5));
    chk("fw_empty", 32'(f_empty), 32'(0));
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, '0);
    chk("fw_valid_drop", 32'(f_valid), 32'(0));
    chk("fw_count0",     32'(f_cnt),   32'(0));

    // hold at 8 words with simultaneous traffic across the pointer wrap
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, sseq(i), 1'b1, 1'b0, fseq(i));
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, sseq(i + 8), 1'b1, 1'b1, fseq(i + 8));
      chk("sim_s_count", 32'(s_cnt),  32'(8));
      chk("sim_f_count", 32'(f_cnt),  32'(8));
      chk("sim_s_dout",  32'(s_dout), 32'(sseq(i)));
      chk("sim_f_dout",  32'(f_dout), 32'(fseq(i + 1)));
    end
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, '0, 1'b0, 1'b1, '0);

    // random traffic in phases biased toward full, empty and balanced
    for (int ph = 0; ph < 4; ph++) begin
      pw = (ph == 0) ? 80 : (ph == 1) ? 25 : (ph == 2) ? 50 : 90;
      pr = (ph == 0) ? 30 : (ph == 1) ? 80 : (ph == 2) ? 50 : 60;
      for (int i = 0; i < 150; i++)
        cyc($urandom_range(99) < pw, $urandom_range(99) < pr, DW'($urandom),
            $urandom_range(99) < pw, $urandom_range(99) < pr, DW'($urandom));
    end

    // mid-operation reset at 5 words, asserted between edges
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, '0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, DW'(16'h0e00 + i), 1'b1, 1'b0, DW'(16'h0f00 + i));
    chk("pre_rst_count", 32'(s_cnt), 32'(5));
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    cmp_all();
    chk("arst_s_count", 32'(s_cnt),  32'(0));
    chk("arst_f_count", 32'(f_cnt),  32'(0));
    chk("arst_s_dout",  32'(s_dout), 32'(0));
    chk("arst_f_dout",  32'(f_dout), 32'(0));
    cyc(1'b1, 1'b1, DW'(16'h1111), 1'b1, 1'b1, DW'(16'h2222));
    chk("rst_req_ack", 32'(s_ack), 32'(0));
    rst = 1'b0;
    cyc(1'b1, 1'b0, DW'(16'h1234), 1'b1, 1'b0, DW'(16'h5678));
    chk("post_f_dout", 32'(f_dout), 32'(16'h5678));
    cyc(1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
    chk("post_s_dout",  32'(s_dout),  32'(16'h1234));
    chk("post_s_valid", 32'(s_valid), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
